// File: rtl/alu_exec_unit.sv
// alu_exec_unit: multi-cycle ALU execute stage.
// An operation is taken in over a valid/ready handshake and evaluated in a
// dedicated execute cycle. The result and its flags are then held until the
// downstream stage accepts them.
// Optional feature: define ALU_STICKY_ERR_EN to build a sticky illegal-code
// flag on o_ErrSticky. Without it, that output is tied low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a new op; latches code/operands when i_Valid is high
// EXEC  | evaluates the latched op and loads the result/flag registers
// DONE  | presents the result with o_Valid; leaves when i_Ready is high
module alu_exec_unit #(
   parameter int NBITS = 32,
   parameter int ALUOP = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_Valid,
   output logic             o_Ready,
   input  logic [ALUOP-1:0] i_ALUCtrl,
   input  logic [NBITS-1:0] i_OpA,
   input  logic [NBITS-1:0] i_OpB,
   output logic             o_Valid,
   input  logic             i_Ready,
   output logic [NBITS-1:0] o_Result,
   output logic             o_Zero,
   output logic             o_Overflow,
   output logic             o_Illegal,
   output logic             o_ErrSticky
);

   localparam logic [ALUOP-1:0] OP_AND = ALUOP'(4'b0000);
   localparam logic [ALUOP-1:0] OP_OR  = ALUOP'(4'b0001);
   localparam logic [ALUOP-1:0] OP_ADD = ALUOP'(4'b0010);
   localparam logic [ALUOP-1:0] OP_SUB = ALUOP'(4'b0110);
   localparam logic [ALUOP-1:0] OP_SLT = ALUOP'(4'b0111);
   localparam logic [ALUOP-1:0] OP_NOR = ALUOP'(4'b1100);
   localparam logic [ALUOP-1:0] OP_XOR = ALUOP'(4'b1101);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic             capture_en;
   logic             load_en;
   logic [ALUOP-1:0] ctrl_q;
   logic [NBITS-1:0] op_a_q;
   logic [NBITS-1:0] op_b_q;

   logic [NBITS-1:0] sum;
   logic [NBITS-1:0] diff;
   logic             add_ovf;
   logic             sub_ovf;
   logic             slt_bit;
   logic [NBITS-1:0] alu_result;
   logic             alu_ovf;
   logic             alu_illegal;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and handshake outputs
   always_comb begin
      state_next = state;
      o_Ready    = 1'b0;
      o_Valid    = 1'b0;
      capture_en = 1'b0;
      load_en    = 1'b0;
      unique case (state)
         IDLE: begin
            o_Ready = 1'b1;
            if (i_Valid) begin
               capture_en = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC: begin
            load_en    = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            o_Valid = 1'b1;
            if (i_Ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Operand/code capture. This happens only on acceptance, so later input changes are ignored.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ctrl_q <= '0;
         op_a_q <= '0;
         op_b_q <= '0;
      end else if (capture_en) begin
         ctrl_q <= i_ALUCtrl;
         op_a_q <= i_OpA;
         op_b_q <= i_OpB;
      end
   end

   // ALU datapath evaluated from the captured operands
   always_comb begin
      sum         = op_a_q + op_b_q;
      diff        = op_a_q - op_b_q;
      // Signed overflow: the result sign disagrees with A although the signs of the effective operands agree
      add_ovf     = (op_a_q[NBITS-1] == op_b_q[NBITS-1]) && (sum[NBITS-1] != op_a_q[NBITS-1]);
      sub_ovf     = (op_a_q[NBITS-1] != op_b_q[NBITS-1]) && (diff[NBITS-1] != op_a_q[NBITS-1]);
      // True signed compare, so it stays correct where A-B would overflow
      slt_bit     = $signed(op_a_q) < $signed(op_b_q);
      alu_result  = '0;
      alu_ovf     = 1'b0;
      alu_illegal = 1'b0;
      case (ctrl_q)
         OP_ADD: begin
            alu_result = sum;
            alu_ovf    = add_ovf;
         end
         OP_SUB: begin
            alu_result = diff;
            alu_ovf    = sub_ovf;
         end
         OP_AND:  alu_result = op_a_q & op_b_q;
         OP_OR:   alu_result = op_a_q | op_b_q;
         OP_NOR:  alu_result = ~(op_a_q | op_b_q);
         OP_XOR:  alu_result = op_a_q ^ op_b_q;
         OP_SLT:  alu_result = {{(NBITS-1){1'b0}}, slt_bit};
         default: alu_illegal = 1'b1;
      endcase
   end

   // Result and flag registers. They load only on the EXEC->DONE edge and hold otherwise.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_Result   <= '0;
         o_Zero     <= 1'b0;
         o_Overflow <= 1'b0;
         o_Illegal  <= 1'b0;
      end else if (load_en) begin
         o_Result   <= alu_result;
         o_Zero     <= (alu_result == '0);
         o_Overflow <= alu_ovf;
         o_Illegal  <= alu_illegal;
      end
   end

`ifdef ALU_STICKY_ERR_EN
   logic err_sticky;

   // Sticky illegal-code flag. Only reset clears it.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         err_sticky <= 1'b0;
      end else if (load_en && alu_illegal) begin
         err_sticky <= 1'b1;
      end
   end

   assign o_ErrSticky = err_sticky;
`else
   assign o_ErrSticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit.
// Stimulus is randomized. Expected results come from an arithmetic reference
// model and go into a scoreboard queue. A monitor checks them whenever the
// unit presents o_Valid.
module tb_alu_exec_unit;
   localparam int NBITS = 32;
   localparam int ALUOP = 4;
`ifdef ALU_STICKY_ERR_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic             i_clk = 1'b0;
   logic             i_reset;
   logic             i_Valid;
   logic             o_Ready;
   logic [ALUOP-1:0] i_ALUCtrl;
   logic [NBITS-1:0] i_OpA;
   logic [NBITS-1:0] i_OpB;
   logic             o_Valid;
   logic             i_Ready;
   logic [NBITS-1:0] o_Result;
   logic             o_Zero;
   logic             o_Overflow;
   logic             o_Illegal;
   logic             o_ErrSticky;

   alu_exec_unit #(.NBITS(NBITS), .ALUOP(ALUOP)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_Valid(i_Valid), .o_Ready(o_Ready),
      .i_ALUCtrl(i_ALUCtrl), .i_OpA(i_OpA), .i_OpB(i_OpB), .o_Valid(o_Valid),
      .i_Ready(i_Ready), .o_Result(o_Result), .o_Zero(o_Zero),
      .o_Overflow(o_Overflow), .o_Illegal(o_Illegal), .o_ErrSticky(o_ErrSticky)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] result;
      bit          zero;
      bit          ovf;
      bit          ill;
      bit          sticky;
      int          acc;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   bit          run = 0;
   bit          prev_valid = 0;
   bit          post_hs = 0;
   bit          sticky_model = 0;
   logic [31:0] last_result = '0;
   bit          last_sticky = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference model: the op rules computed with wide signed arithmetic
   function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa, sb, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.result = '0; e.ovf = 0; e.ill = 0; e.acc = 0; e.sticky = 0;
      case (c)
         4'b0010: begin s = sa + sb; e.result = 32'(s); e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'b0110: begin s = sa - sb; e.result = 32'(s); e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
         4'b0000: e.result = a & b;
         4'b0001: e.result = a | b;
         4'b1100: e.result = ~(a | b);
         4'b1101: e.result = a ^ b;
         4'b0111: e.result = (sa < sb) ? 32'd1 : 32'd0;
         default: e.ill = 1;
      endcase
      e.zero = (e.result == 32'd0);
      return e;
   endfunction

   // Monitor: compares presented results against the scoreboard and checks that outputs hold while idle
   always @(negedge i_clk) begin
      if (run && !i_reset) begin
         if (post_hs) begin
            chk("valid_after_handoff", o_Valid, 0);
            chk("ready_after_handoff", o_Ready, 1);
         end
         post_hs = 0;
         if (o_Valid) begin
            if (q.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               mon_e = q[0];
               if (!prev_valid) chk("latency", cyc, mon_e.acc + 2);
               chk("result", o_Result, mon_e.result);
               chk("zero", o_Zero, mon_e.zero);
               chk("overflow", o_Overflow, mon_e.ovf);
               chk("illegal", o_Illegal, mon_e.ill);
               chk("sticky", o_ErrSticky, mon_e.sticky);
               chk("ready_in_done", o_Ready, 0);
               if (i_Ready) begin
                  void'(q.pop_front());
                  last_result = mon_e.result;
                  last_sticky = mon_e.sticky;
                  post_hs = 1;
               end
            end
         end else begin
            chk("result_hold", o_Result, last_result);
            chk("sticky_hold", o_ErrSticky, last_sticky);
         end
         prev_valid = o_Valid;
      end else begin
         prev_valid = 0;
         post_hs = 0;
      end
   end

   task automatic check_reset_state(input string tag);
      chk({tag, "_ready"}, o_Ready, 1);
      chk({tag, "_valid"}, o_Valid, 0);
      chk({tag, "_result"}, o_Result, 0);
      chk({tag, "_zero"}, o_Zero, 0);
      chk({tag, "_ovf"}, o_Overflow, 0);
      chk({tag, "_illegal"}, o_Illegal, 0);
      chk({tag, "_sticky"}, o_ErrSticky, 0);
   endtask

   // Called at posedge+1; returns at posedge+1
   task automatic do_reset(input string tag);
      i_reset = 1;
      @(posedge i_clk); #1;
      i_reset = 0;
      q.delete();
      last_result = '0;
      last_sticky = 0;
      sticky_model = 0;
      @(negedge i_clk);
      check_reset_state(tag);
      @(posedge i_clk); #1;
   endtask

   // Called at posedge+1; returns at posedge+1 just after the handoff edge
   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input int stall_n, input bit rst_exec);
      exp_t e;
      bit   ok;
      int   stalled;
      i_Valid = 1; i_ALUCtrl = c; i_OpA = a; i_OpB = b;
      ok = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge i_clk);
         if (o_Ready) begin
            e = model(c, a, b);
            sticky_model = sticky_model | (STICKY & e.ill);
            e.sticky = sticky_model;
            e.acc = cyc;
            q.push_back(e);
            ok = 1;
            break;
         end
         @(posedge i_clk); #1;
      end
      if (!ok) begin
         chk("accept_timeout", 0, 1);
         i_Valid = 0;
         return;
      end
      @(posedge i_clk); #1;
      i_Valid = 0; i_OpA = $urandom; i_OpB = $urandom; i_ALUCtrl = 4'($urandom);
      if (rst_exec) begin
         do_reset("rst_exec");
         return;
      end
      ok = 0;
      stalled = 0;
      for (int t = 0; t < 60; t++) begin
         @(negedge i_clk);
         if (o_Valid && i_Ready) begin ok = 1; break; end
         @(posedge i_clk); #1;
         if (o_Valid) begin
            if (stalled < stall_n) begin
               i_Ready = 0; i_Valid = 1'($urandom_range(0, 1)); i_OpA = $urandom;
               stalled++;
            end else begin
               i_Valid = 0;
               i_Ready = ($urandom_range(0, 3) != 0);
            end
         end else begin
            i_Ready = 1'($urandom_range(0, 1));
         end
      end
      if (!ok) chk("done_timeout", 0, 1);
      @(posedge i_clk); #1;
      i_Ready = 0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      i_reset = 1; i_Valid = 0; i_Ready = 0; i_ALUCtrl = '0; i_OpA = '0; i_OpB = '0;
      repeat (3) @(posedge i_clk);
      #1 i_reset = 0;
      @(negedge i_clk);
      check_reset_state("reset");
      run = 1;
      @(posedge i_clk); #1;

      issue(4'b0010, 32'h0000_0005, 32'h0000_0003, 0, 0);
      issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0);
      issue(4'b0110, 32'h8000_0000, 32'h0000_0001, 0, 0);
      issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
      issue(4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0);
      issue(4'b0110, 32'h0000_1234, 32'h0000_1234, 0, 0);
      issue(4'b1100, 32'h0F0F_0000, 32'h0000_00F0, 0, 0);
      issue(4'b1101, 32'hA5A5_A5A5, 32'hFFFF_0000, 0, 0);
      issue(4'b0000, 32'hDEAD_BEEF, 32'h0000_FFFF, 10, 0);
      issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
      issue(4'b0001, 32'h0000_0010, 32'h0000_0001, 0, 0);
      issue(4'b1110, 32'h0000_0001, 32'h0000_0001, 0, 0);
      do_reset("rst_clear");
      issue(4'b0001, 32'h0000_0003, 32'h0000_0004, 0, 0);
      issue(4'b0010, 32'h1111_1111, 32'h2222_2222, 0, 1);
      issue(4'b0001, 32'h0000_0000, 32'h0000_0000, 0, 0);

      for (int n = 0; n < 150; n++) begin
         issue(4'($urandom_range(0, 15)), pick(), pick(),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 0,
               ($urandom_range(0, 24) == 0));
      end

      repeat (3) @(posedge i_clk);
      chk("scoreboard_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
